bsg_chip_comm_link_credit_tx: RTL and testbench
===============================================

# bsg_chip_comm_link_credit_tx

Credit-based transmitter for one outbound comm-link channel (valid + 9-bit data out, token back). It sits in bsg_chip_guts on the co/co2 side, ahead of the swizzle adapter. It accepts words from the core over a valid/ready handshake and drives registered chan_v_o/chan_data_o. It sends only while the far-end receiver has buffer credit, and replenishes credit from the asynchronous token wire returned by the neighbouring chip.

## Interface
- width_p, 9: channel data width.
- credits_p, 16: receiver buffer depth; initial credit count. Must be a multiple of 2^lg_decimation_p.
- lg_decimation_p, 2: each token event returns 2^lg_decimation_p credits.
- cw = $clog2(credits_p+1) (localparam): credit counter width.

Ports:
- clk_i  in  1  core clock; all state on the rising edge.
- reset_n_i  in  1  asynchronous, active-low reset.
- v_i  in  1  core word valid.
- data_i  in  width_p  core word.
- ready_o  out  1  transmitter can accept; equals (credits != 0), combinational from the credit register.
- chan_v_o  out  1  channel valid, registered.
- chan_data_o  out  width_p  channel data, registered.
- chan_tkn_i  in  1  token wire from the far chip; asynchronous to clk_i.
- credits_o  out  cw  current credit count.
- err_overflow_o  out  1  sticky flag: returned credit would have exceeded credits_p.

## Operation
- **Accept.** A word is accepted when v_i & ready_o. The next edge sets chan_v_o=1, chan_data_o=data_i, and credits decrements by 1.
- **Idle.** With no accept, the next edge sets chan_v_o=0. chan_data_o holds its last value to avoid needless toggling.
- **Token synchronizer.** chan_tkn_i passes through two flops, s1 then s2. A third flop, s3, captures s2.
- **Token event.** tkn_evt = s2 & ~s3, i.e. one event per rising edge of chan_tkn_i. Falling edges return nothing.
- **Credit update.** next = credits − accept + (tkn_evt ? 2^lg_decimation_p : 0), computed at cw+1 bits.
  - If next > credits_p: credits ← credits_p and err_overflow_o ← 1.
  - err_overflow_o stays set until reset.
- **Simultaneous events.** An accept and a token event in the same cycle net together in the one update.
- **Zero credit.** ready_o=0 and no accept occurs. A core word held on v_i waits, with no loss or duplication.
- **Ordering.** Words leave in acceptance order, one per cycle maximum. There is no internal buffering beyond the output register.
- **Reset.** Asserting reset_n_i low forces, immediately and without waiting for a clock edge:
  - chan_v_o=0 and chan_data_o=0;
  - credits=credits_p, so ready_o=1;
  - s1, s2, s3 = 0;
  - err_overflow_o=0.
- **Reset mid-operation.** Any word in flight on the channel register is dropped. Both chips reset together, so the receiver's buffer is empty and its token line is low.
- **Protocol violation at reset.** chan_tkn_i high at reset release is a violation. It yields one spurious event, which saturates at credits_p and raises err_overflow_o.

## Timing
- Accept to channel: 1 cycle. A word accepted at edge k appears on chan_v_o/chan_data_o after edge k.
- Accept to credits_o/ready_o: the decrement is visible after the same edge k.
- Token latency: chan_tkn_i rising with setup before edge k gives s1 at k, s2 at k+1, and credits_o incremented after edge k+2 (3 edges).
- Token pulse rules:
  - chan_tkn_i high and low must each be stable for at least 2 clk_i cycles.
  - Shorter pulses may be missed; this is a far-end requirement.
- Throughput: 1 word/cycle while credits > 0. Sustained rate is bounded by the token return rate.
- Reset assertion is asynchronous. Deassertion must be synchronized externally to clk_i.

## Test plan
- **Reset.** Hold reset_n_i=0, then release → credits_o=16, ready_o=1, chan_v_o=0, chan_data_o=0, err_overflow_o=0.
- **Burst to zero credit.** Drive 17 back-to-back words with data 0x000..0x010, v_i=1 →
  - chan_v_o high for 16 consecutive cycles carrying 0x000..0x00F, each one cycle after accept;
  - credits_o reaches 0 and ready_o=0;
  - 0x010 is held, not sent.
- **Token return.** At credits 0 with 0x010 pending, raise chan_tkn_i for 4 cycles →
  - credits_o=4 after the 3rd edge;
  - 0x010 is sent on the next cycle, credits_o=3;
  - exactly one event per rising edge, none on the falling edge.
- **Simultaneous accept and token.** At credits 1, an accept coincides with tkn_evt → credits_o=4 (1−1+4). No overflow.
- **Overflow.** At credits 16 with no traffic, deliver a token rising edge → credits_o stays 16, err_overflow_o=1, and it remains 1 through later traffic until reset.
- **Reset mid-burst.** Drop reset_n_i between edges while chan_v_o=1 and credits=5 → chan_v_o=0 and credits_o=16 without a clock edge. After release, first accepted data appears normally 1 cycle later.

Source files
------------

// File: rtl/bsg_chip_comm_link_credit_tx.sv
// Credit-based transmitter for one outbound comm-link channel: registered valid/data out,
// credits spent per word and replenished by rising edges of the asynchronous token wire.
module bsg_chip_comm_link_credit_tx #(
    parameter int width_p         = 9,
    parameter int credits_p       = 16,
    parameter int lg_decimation_p = 2,
    localparam int cw             = $clog2(credits_p + 1)
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               chan_v_o,
    output logic [width_p-1:0] chan_data_o,
    input  logic               chan_tkn_i,
    output logic [cw-1:0]      credits_o,
    output logic               err_overflow_o
);

    // One extra bit so a token return on top of a full counter is visible before saturation.
    localparam logic [cw:0] credits_max_c   = (cw + 1)'(credits_p);
    localparam logic [cw:0] token_credits_c = (cw + 1)'(1 << lg_decimation_p);

    logic [cw-1:0] credits_r;
    logic          s1_r, s2_r, s3_r;
    logic          accept;
    logic          tkn_evt;
    logic [cw:0]   credits_sum;
    logic [cw-1:0] credits_next;
    logic          overflow;

    assign ready_o   = (credits_r != '0);
    assign accept    = v_i & ready_o;
    assign tkn_evt   = s2_r & ~s3_r;
    assign credits_o = credits_r;

    // NOTE: every signal written here gets an unconditional first assignment, so no latch is inferred.
    always_comb begin
        credits_sum = {1'b0, credits_r} - {{cw{1'b0}}, accept};
        if (tkn_evt) begin
            credits_sum = credits_sum + token_credits_c;
        end
        overflow     = (credits_sum > credits_max_c);
        credits_next = overflow ? credits_max_c[cw-1:0] : credits_sum[cw-1:0];
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
            s3_r <= 1'b0;
        end else begin
            s1_r <= chan_tkn_i;
            s2_r <= s1_r;
            s3_r <= s2_r;
        end
    end

    // Data holds when idle to avoid toggling the pad drivers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            chan_v_o    <= 1'b0;
            chan_data_o <= '0;
        end else begin
            chan_v_o <= accept;
            if (accept) begin
                chan_data_o <= data_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            credits_r      <= credits_max_c[cw-1:0];
            err_overflow_o <= 1'b0;
        end else begin
            credits_r <= credits_next;
            if (overflow) begin
                err_overflow_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bsg_chip_comm_link_credit_tx.sv
// Self-checking bench for bsg_chip_comm_link_credit_tx against a cycle-level credit/token model.
module tb_bsg_chip_comm_link_credit_tx;

    localparam int W   = 9;
    localparam int C   = 16;
    localparam int LGD = 2;
    localparam int CW  = $clog2(C + 1);
    localparam int VW  = 1 + W + CW + 1 + 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          v = 1'b0;
    logic [W-1:0]  data = '0;
    logic          tkn = 1'b0;
    logic          ready;
    logic          chan_v;
    logic [W-1:0]  chan_data;
    logic [CW-1:0] credits;
    logic          err;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: credit count, sticky error, last channel word, token level seen at each edge.
    int           m_credits;
    bit           m_err;
    bit           m_v;
    logic [W-1:0] m_data;
    bit           tq[$];

    bsg_chip_comm_link_credit_tx #(
        .width_p(W), .credits_p(C), .lg_decimation_p(LGD)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n), .v_i(v), .data_i(data), .ready_o(ready),
        .chan_v_o(chan_v), .chan_data_o(chan_data), .chan_tkn_i(tkn),
        .credits_o(credits), .err_overflow_o(err)
    );

    always #5 clk = ~clk;

    function automatic logic [VW-1:0] model_vec();
        return {m_v, m_data, CW'(m_credits), (m_credits != 0), m_err};
    endfunction

    function automatic logic [VW-1:0] dut_vec();
        return {chan_v, chan_data, credits, ready, err};
    endfunction

    task automatic model_reset();
        m_credits = C;
        m_err     = 1'b0;
        m_v       = 1'b0;
        m_data    = '0;
        tq        = '{1'b0, 1'b0, 1'b0};
    endtask

    // A token is credited at edge e when the wire was seen high at e-2 and low at e-3.
    task automatic model_edge();
        bit acc;
        bit evt;
        int nxt;
        acc = v && (m_credits != 0);
        evt = tq[tq.size()-2] && !tq[tq.size()-3];
        nxt = m_credits - int'(acc) + (evt ? (1 << LGD) : 0);
        if (nxt > C) begin
            m_credits = C;
            m_err     = 1'b1;
        end else begin
            m_credits = nxt;
        end
        m_v = acc;
        if (acc) m_data = data;
        tq.push_back(tkn);
        if (tq.size() > 8) void'(tq.pop_front());
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        v       = 1'b0;
        tkn     = 1'b0;
        model_reset();
        #2;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        #1 reset_n = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if (dut_vec() !== model_vec()) begin
            n_fail++; $display("FAIL reset_async: got %h expected %h", dut_vec(), model_vec());
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b1;
        tick();
        n_tests++;
        if (credits !== CW'(C) || ready !== 1'b1 || chan_v !== 1'b0 || chan_data !== '0 || err !== 1'b0) begin
            n_fail++; $display("FAIL reset_release: got %h expected credits=16 ready=1 v=0 data=0 err=0", dut_vec());
        end
    endtask

    task automatic test_burst();
        int sent;
        sent = 0;
        for (int i = 0; i <= 16; i++) begin
            v    = 1'b1;
            data = W'(i);
            tick();
            if (chan_v === 1'b1) sent++;
            n_tests++;
            if (dut_vec() !== model_vec()) begin
                n_fail++; $display("FAIL burst[%0d]: got %h expected %h", i, dut_vec(), model_vec());
            end
        end
        // Word 0x010 stays held on v_i with no credit left.
        for (int i = 0; i < 2; i++) begin
            tick();
            if (chan_v === 1'b1) sent++;
        end
        n_tests++;
        if (sent !== 16 || credits !== '0 || ready !== 1'b0 || chan_data !== W'(15)) begin
            n_fail++; $display("FAIL burst_zero: sent %0d credits %0d ready %b data %h, expected 16 0 0 00f",
                               sent, credits, ready, chan_data);
        end
    endtask

    task automatic test_token();
        tkn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (dut_vec() !== model_vec()) begin
                n_fail++; $display("FAIL token[%0d]: got %h expected %h", i, dut_vec(), model_vec());
            end
        end
        n_tests++;
        if (credits !== CW'(4) || chan_v !== 1'b0) begin
            n_fail++; $display("FAIL token_latency: credits %0d v %b, expected 4 0", credits, chan_v);
        end
        tick();
        n_tests++;
        if (chan_v !== 1'b1 || chan_data !== W'(16) || credits !== CW'(3)) begin
            n_fail++; $display("FAIL token_release: v %b data %h credits %0d, expected 1 010 3", chan_v, chan_data, credits);
        end
        v   = 1'b0;
        tkn = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_tests++;
            if (dut_vec() !== model_vec()) begin
                n_fail++; $display("FAIL token_fall[%0d]: got %h expected %h", i, dut_vec(), model_vec());
            end
        end
        n_tests++;
        if (credits !== CW'(3)) begin
            n_fail++; $display("FAIL token_no_fall_event: credits %0d, expected 3", credits);
        end
    endtask

    task automatic test_simultaneous();
        v = 1'b1;
        for (int i = 0; i < 2; i++) begin
            data = W'($urandom);
            tick();
        end
        v   = 1'b0;
        tkn = 1'b1;
        tick();
        tick();
        n_tests++;
        if (credits !== CW'(1)) begin
            n_fail++; $display("FAIL simul_setup: credits %0d, expected 1", credits);
        end
        v    = 1'b1;
        data = W'($urandom);
        tick();
        n_tests++;
        if (credits !== CW'(4) || err !== 1'b0 || chan_v !== 1'b1 || dut_vec() !== model_vec()) begin
            n_fail++; $display("FAIL simul_net: got %h expected %h (credits 4)", dut_vec(), model_vec());
        end
        v   = 1'b0;
        tkn = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_overflow();
        do_reset();
        tkn = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        n_tests++;
        if (credits !== CW'(C) || err !== 1'b1) begin
            n_fail++; $display("FAIL overflow: credits %0d err %b, expected 16 1", credits, err);
        end
        tkn = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 6; i++) begin
            v    = 1'($urandom);
            data = W'($urandom);
            tick();
            n_tests++;
            if (dut_vec() !== model_vec()) begin
                n_fail++; $display("FAIL overflow_sticky[%0d]: got %h expected %h", i, dut_vec(), model_vec());
            end
        end
        n_tests++;
        if (err !== 1'b1) begin
            n_fail++; $display("FAIL overflow_hold: err %b, expected 1", err);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        v = 1'b1;
        for (int i = 0; i < 11; i++) begin
            data = W'($urandom);
            tick();
        end
        n_tests++;
        if (chan_v !== 1'b1 || credits !== CW'(5)) begin
            n_fail++; $display("FAIL mid_setup: v %b credits %0d, expected 1 5", chan_v, credits);
        end
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if (chan_v !== 1'b0 || credits !== CW'(C) || dut_vec() !== model_vec()) begin
            n_fail++; $display("FAIL mid_async: got %h expected %h", dut_vec(), model_vec());
        end
        reset_n = 1'b1;
        data    = 9'h1a5;
        tick();
        n_tests++;
        if (chan_v !== 1'b1 || chan_data !== 9'h1a5 || credits !== CW'(C - 1)) begin
            n_fail++; $display("FAIL mid_after: v %b data %h credits %0d, expected 1 1a5 15", chan_v, chan_data, credits);
        end
        v = 1'b0;
    endtask

    task automatic test_random();
        int hold;
        do_reset();
        hold = 3;
        for (int i = 0; i < 400; i++) begin
            v    = ($urandom_range(0, 9) < 8);
            data = W'($urandom);
            hold--;
            if (hold == 0) begin
                tkn  = ~tkn;
                hold = $urandom_range(2, 5);
            end
            tick();
            n_tests++;
            if (dut_vec() !== model_vec()) begin
                n_fail++; $display("FAIL random[%0d]: got %h expected %h", i, dut_vec(), model_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_burst();
        test_token();
        test_simultaneous();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
